// File: rtl/play_buttons_pkg.sv
// Shared symbol encoding and state type for the button capture and playback blocks.
package play_buttons_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [1:0] btn_sym_t;

    localparam btn_sym_t SYM_BTN0    = 2'b00;
    localparam btn_sym_t SYM_BTN1    = 2'b01;
    localparam btn_sym_t SYM_BTN2    = 2'b10;
    localparam int       NUM_SYMBOLS = 4;

    // Code 2'b11 is a blank slot: no LED, but it still occupies a full window.
    function automatic logic [2:0] sym_to_leds(input btn_sym_t sym);
        logic [2:0] leds;
        case (sym)
            SYM_BTN0: leds = 3'b001;
            SYM_BTN1: leds = 3'b010;
            SYM_BTN2: leds = 3'b100;
            default:  leds = 3'b000;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/play_buttons_interval_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/play_buttons.sv
// Plays a 4-symbol button code on three one-hot LEDs with timed ON windows and OFF gaps.
// Optional abort input is enabled by defining PLAY_BUTTONS_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, LEDs dark
// ON    | current symbol lit, timer counting ON window
// OFF   | LEDs dark, timer counting gap after the symbol
// DONE  | all symbols shown, done held until next start
module play_buttons
    import play_buttons_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int ON_TIME_US    = 500_000,
    parameter int OFF_TIME_US   = 250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef PLAY_BUTTONS_ABORT_EN
    input  logic       abort,
`endif
    input  logic [7:0] btns_in,
    output logic       busy,
    output logic       done,
    output logic [2:0] leds_out
);

    localparam int ON_CYCLES  = CLK_FREQUENCY / 1_000_000 * ON_TIME_US;
    localparam int OFF_CYCLES = CLK_FREQUENCY / 1_000_000 * OFF_TIME_US;
    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [1:0]         LAST_IDX = 2'(NUM_SYMBOLS - 1);

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [2:0]   leds_q, leds_d;
    logic [1:0]   idx_q, idx_d;
    logic [7:0]   sym_q, sym_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expired;

    interval_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        leds_d   = leds_q;
        idx_d    = idx_q;
        sym_d    = sym_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ON;
                    sym_d    = btns_in;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    leds_d   = sym_to_leds(btns_in[1:0]);
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end
            ON: begin
                if (tmr_expired) begin
                    state_d  = OFF;
                    leds_d   = 3'b000;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            OFF: begin
                if (tmr_expired) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next symbol is pre-decoded so it lights on the first ON cycle.
                        state_d  = ON;
                        idx_d    = idx_q + 1'b1;
                        sym_d    = {2'b00, sym_q[7:2]};
                        leds_d   = sym_to_leds(sym_q[3:2]);
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                leds_d  = 3'b000;
            end
        endcase

`ifdef PLAY_BUTTONS_ABORT_EN
        if (abort && (state_q == ON || state_q == OFF)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            leds_d   = 3'b000;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            leds_q  <= 3'b000;
            idx_q   <= '0;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            leds_q  <= leds_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign leds_out = leds_q;

endmodule

// File: tb/tb_play_buttons.sv
// Directed bench for play_buttons with ON=4 and OFF=2 cycles.
module tb_play_buttons;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] btns_in = 8'h00;
   logic       busy;
   logic       done;
   logic [2:0] leds_out;

   int checks = 0;
   int failures = 0;

   play_buttons #(
      .CLK_FREQUENCY (1_000_000),
      .ON_TIME_US    (4),
      .OFF_TIME_US   (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
`ifdef PLAY_BUTTONS_ABORT_EN
      .abort    (abort),
`endif
      .btns_in  (btns_in),
      .busy     (busy),
      .done     (done),
      .leds_out (leds_out)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] exp_leds(input logic [7:0] code, input int c);
      int slot;
      int pos;
      logic [1:0] s;
      if (c < 1 || c > 24) return 3'b000;
      slot = (c - 1) / 6;
      pos  = (c - 1) % 6;
      if (pos >= 4) return 3'b000;
      s = code[2*slot +: 2];
      case (s)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
   // Returns at the falling edge inside cycle ncyc without advancing past it.
   task automatic play(input logic [7:0] code, input int ncyc, input int extra_cyc,
                       input logic [7:0] extra_code, input string tag, output int nbusy);
      logic [2:0] el;
      logic       eb;
      logic       ed;
      nbusy   = 0;
      btns_in = code;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      btns_in = ~code;
      for (int c = 1; c <= ncyc; c++) begin
         el = exp_leds(code, c);
         eb = (c <= 24);
         ed = (c >= 25);
         checks++;
         if (leds_out !== el) begin
            failures++;
            $error("FAIL %s_leds c=%0d observed=%0h expected=%0h", tag, c, leds_out, el);
         end
         checks++;
         if (busy !== eb) begin
            failures++;
            $error("FAIL %s_busy c=%0d observed=%0h expected=%0h", tag, c, busy, eb);
         end
         checks++;
         if (done !== ed) begin
            failures++;
            $error("FAIL %s_done c=%0d observed=%0h expected=%0h", tag, c, done, ed);
         end
         if (busy === 1'b1) nbusy++;
         if (c == ncyc) break;
         if (c == extra_cyc) begin
            start   = 1'b1;
            btns_in = extra_code;
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nb;
      #3 reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $error("FAIL rst_busy observed=%0h expected=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $error("FAIL rst_done observed=%0h expected=0", done); end
      checks++;
      if (leds_out !== 3'b000) begin failures++; $error("FAIL rst_leds observed=%0h expected=0", leds_out); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (leds_out !== 3'b000) begin failures++; $error("FAIL idle_leds observed=%0h expected=0", leds_out); end

      play(8'b10_01_00_10, 25, -1, 8'h00, "t1", nb);
      checks++;
      if (nb !== 24) begin failures++; $error("FAIL t1_nbusy observed=%0d expected=24", nb); end
      checks++;
      if (exp_leds(8'b10_01_00_10, 1) !== 3'b100) begin
         failures++;
         $error("FAIL t1_c1_leds observed=%0h expected=4", exp_leds(8'b10_01_00_10, 1));
      end

      @(negedge clk);
      play(8'hFF, 25, -1, 8'h00, "t2", nb);
      checks++;
      if (nb !== 24) begin failures++; $error("FAIL t2_nbusy observed=%0d expected=24", nb); end

      play(8'b10_01_00_10, 25, 10, 8'h1B, "t3", nb);
      checks++;
      if (nb !== 24) begin failures++; $error("FAIL t3_nbusy observed=%0d expected=24", nb); end
      play(8'b00_00_00_01, 9, -1, 8'h00, "t3r", nb);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (leds_out !== 3'b000) begin failures++; $error("FAIL t4_rst_leds observed=%0h expected=0", leds_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $error("FAIL t4_rst_busy observed=%0h expected=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $error("FAIL t4_rst_done observed=%0h expected=0", done); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $error("FAIL t4_idle_busy observed=%0h expected=0", busy); end

      play(8'b01_10_11_00, 25, 24, 8'hAA, "t4", nb);
      checks++;
      if (nb !== 24) begin failures++; $error("FAIL t4_nbusy observed=%0d expected=24", nb); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin failures++; $error("FAIL t4_hold_done observed=%0h expected=1", done); end
      checks++;
      if (leds_out !== 3'b000) begin failures++; $error("FAIL t4_hold_leds observed=%0h expected=0", leds_out); end

`ifdef PLAY_BUTTONS_ABORT_EN
      play(8'b10_01_00_10, 8, -1, 8'h00, "t5", nb);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (leds_out !== 3'b000) begin failures++; $error("FAIL t5_ab_leds observed=%0h expected=0", leds_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $error("FAIL t5_ab_busy observed=%0h expected=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $error("FAIL t5_ab_done observed=%0h expected=0", done); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $error("FAIL t5_idle_busy observed=%0h expected=0", busy); end
      play(8'b00_00_00_01, 2, -1, 8'h00, "t5r", nb);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/play_buttons.md
Name: play_buttons

Overview:
- Transmit-side counterpart to the 4-press button capture block.
- Takes an 8-bit code of four 2-bit button symbols and plays it back on three LEDs, one symbol at a time.
- Each symbol is lit for a timed ON window, followed by a dark OFF gap.
- Used in the human-timing design to show a challenge sequence before the user enters it on the buttons.

Parameters:
- CLK_FREQUENCY, 100_000_000: clock frequency in Hz.
- ON_TIME_US, 500_000: LED lit time per symbol, in µs. ON_CYCLES = CLK_FREQUENCY/1_000_000*ON_TIME_US. Must be ≥1.
- OFF_TIME_US, 250_000: dark gap after each symbol, in µs. OFF_CYCLES computed the same way. Must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin playback
- btns_in  input  8  four 2-bit symbols; symbol k = btns_in[2k+1:2k]; k=0 plays first
- busy  output  1  high while playback is in progress
- done  output  1  level; high after all 4 symbols have played, until the next start or reset
- leds_out  output  3  one-hot LED drive for the current symbol; 0 during gaps and when idle

Behaviour:
- Reset (asynchronous, reset==0) clears all state in the same instant:
  - state=IDLE, busy=0, done=0, leds_out=0, symbol index=0, timer=0.
- Symbol decode:
  - 2'b00 -> leds_out=3'b001
  - 2'b01 -> 3'b010
  - 2'b10 -> 3'b100
  - 2'b11 -> 3'b000 (blank slot, but still timed as a full ON window)
- States: IDLE, ON, OFF, DONE.
- IDLE or DONE with start==1 at edge t:
  - latch btns_in into an internal shift register; index=0; done=0; busy=1.
  - enter ON with timer=ON_CYCLES-1.
  - leds_out shows symbol 0 from cycle t+1.
  - btns_in is ignored after the latch cycle.
- ON: timer decrements each cycle; leds_out=decode(current symbol). When timer==0: go to OFF, timer=OFF_CYCLES-1, leds_out=0.
  - Each symbol is lit for exactly ON_CYCLES cycles.
- OFF: leds_out=0. When timer==0:
  - if index==3: go to DONE.
  - else: index++, shift to the next symbol, go to ON with timer=ON_CYCLES-1.
  - Each gap lasts exactly OFF_CYCLES cycles.
- DONE: busy=0, done=1, leds_out=0. Held until start or reset.
- Total busy time = 4*(ON_CYCLES+OFF_CYCLES) cycles. done rises the cycle after the last OFF cycle.
- start while busy: ignored; no restart, no re-latch.
- start in the same cycle that the last OFF expires: ignored (state is still OFF). The block enters DONE; a later start is accepted.
- Reset mid-playback: LEDs go dark immediately, and the block returns to IDLE with done=0.
- Timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)+1). Unsigned; never wraps below 0 because expiry is checked at 0.
- All outputs are registered.

Optional Feature:
- Macro: PLAY_BUTTONS_ABORT_EN
- When defined, adds input port abort (1 bit).
  - abort==1 at a clock edge in ON or OFF: next state is IDLE, leds_out=0, busy=0, done stays 0.
  - abort has priority over timer expiry.
  - abort in IDLE or DONE has no effect.
- When not defined, no abort port exists and playback always runs to completion.

Decomposition:
- Package play_buttons_pkg contains:
  - state enum (IDLE/ON/OFF/DONE)
  - typedef logic [1:0] btn_sym_t
  - constants SYM_BTN0=2'b00, SYM_BTN1=2'b01, SYM_BTN2=2'b10, NUM_SYMBOLS=4
  - function sym_to_leds(btn_sym_t) returning logic [2:0]
- The capture block also imports this package, so both ends share one encoding.
- One sub-module: interval_timer (parameter WIDTH; ports clk, reset, load, load_val, expired), a loadable down-counter.

Test Plan:
- Bench parameters: CLK_FREQUENCY=1_000_000, ON_TIME_US=4, OFF_TIME_US=2, giving ON=4 and OFF=2 cycles.
- Test 1: start=1 at cycle 0 with btns_in=8'b10_01_00_10.
  - leds_out = 100 for cycles 1-4, 0 for 5-6, 001 for 7-10, 0 for 11-12, 010 for 13-16, 0 for 17-18, 100 for 19-22, 0 for 23-24.
  - done=1 and busy=0 from cycle 25.
- Test 2: btns_in=8'b11_11_11_11.
  - leds_out stays 0 throughout; busy is high for exactly 24 cycles; then done=1.
- Test 3: second start at cycle 10 with a different btns_in.
  - Ignored: sequence and timing identical to Test 1. Then start in DONE restarts playback: done falls, leds light on the next cycle.
- Test 4: reset=0 asserted asynchronously at cycle 9.
  - leds_out, busy and done go to 0 before the next edge; a later start replays from symbol 0.
- Test 5: with PLAY_BUTTONS_ABORT_EN defined, abort=1 at cycle 8.
  - From cycle 9: leds_out=0, busy=0, done=0; the state is IDLE, so a subsequent start is accepted.
